// File: rtl/receptor_serial.sv
// receptor_serial: framed 5-bit serial word receiver with parity and stop-bit checks
module receptor_serial #(
   parameter bit PARITY_EN = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       x,
   input  logic       en,
   output logic [4:0] data,
   output logic       valid,
   output logic       par_err,
   output logic       frm_err,
   output logic       busy
);
   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
   state_t     r_state, w_state;
   logic [2:0] r_cnt, w_cnt;
   logic [4:0] r_shreg, w_shreg;
   logic       r_pbit, w_pbit;
   logic [4:0] r_data, w_data;
   logic       r_valid, w_valid;
   logic       r_par_err, w_par_err;
   logic       r_frm_err, w_frm_err;
   // next state and next outputs; nothing moves without the bit-time strobe
   always_comb begin
      w_state   = r_state;
      w_cnt     = r_cnt;
      w_shreg   = r_shreg;
      w_pbit    = r_pbit;
      w_data    = r_data;
      w_par_err = r_par_err;
      w_frm_err = r_frm_err;
      w_valid   = 1'b0;
      if (en) begin
         case (r_state)
            IDLE: if (!x) begin
               w_state = DATA;
               w_cnt   = 3'd0;
               w_shreg = 5'd0;
            end
            DATA: if (r_cnt > 3'd4) begin
               w_state = IDLE;
               w_cnt   = 3'd0;
            end else begin
               w_shreg = {x, r_shreg[4:1]};
               w_cnt   = (r_cnt == 3'd4) ? 3'd0 : r_cnt + 3'd1;
               if (r_cnt == 3'd4) w_state = PARITY_EN ? PARITY : STOP;
            end
            PARITY: begin
               w_pbit  = x;
               w_state = STOP;
            end
            STOP: begin
               w_data    = r_shreg;
               w_valid   = 1'b1;
               w_frm_err = ~x;
               w_par_err = PARITY_EN & (^r_shreg ^ r_pbit);
               w_state   = IDLE;
            end
            default: w_state = IDLE;
         endcase
      end
   end
   // state and output registers, cleared immediately by reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= IDLE;
         r_cnt     <= 3'd0;
         r_shreg   <= 5'd0;
         r_pbit    <= 1'b0;
         r_data    <= 5'd0;
         r_valid   <= 1'b0;
         r_par_err <= 1'b0;
         r_frm_err <= 1'b0;
      end else begin
         r_state   <= w_state;
         r_cnt     <= w_cnt;
         r_shreg   <= w_shreg;
         r_pbit    <= w_pbit;
         r_data    <= w_data;
         r_valid   <= w_valid;
         r_par_err <= w_par_err;
         r_frm_err <= w_frm_err;
      end
   end
   assign data    = r_data;
   assign valid   = r_valid;
   assign par_err = r_par_err;
   assign frm_err = r_frm_err;
   assign busy    = (r_state != IDLE);
endmodule

// File: tb/tb_receptor_serial.sv
// tb_receptor_serial: directed frame vectors and corner sequences for receptor_serial
module tb_receptor_serial;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       x = 1'b1;
   logic       en = 1'b0;
   logic [4:0] data_p, data_n;
   logic       valid_p, valid_n, par_p, par_n, frm_p, frm_n, busy_p, busy_n;
   int         cyc = 0;
   int         vcnt_p = 0, vcnt_n = 0, vcyc_p = 0, vcyc_n = 0, bcnt_p = 0, bcnt_n = 0;
   int         nchk = 0, nerr = 0;

   receptor_serial #(.PARITY_EN(1'b1)) u_p (
      .clk(clk), .reset(reset), .x(x), .en(en), .data(data_p), .valid(valid_p),
      .par_err(par_p), .frm_err(frm_p), .busy(busy_p));
   receptor_serial #(.PARITY_EN(1'b0)) u_n (
      .clk(clk), .reset(reset), .x(x), .en(en), .data(data_n), .valid(valid_n),
      .par_err(par_n), .frm_err(frm_n), .busy(busy_n));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   // observe valid pulses and busy cycles away from the active edge
   always @(negedge clk) begin
      if (valid_p) begin vcnt_p <= vcnt_p + 1; vcyc_p <= cyc; end
      if (valid_n) begin vcnt_n <= vcnt_n + 1; vcyc_n <= cyc; end
      if (busy_p) bcnt_p <= bcnt_p + 1;
      if (busy_n) bcnt_n <= bcnt_n + 1;
   end

   typedef struct {
      string      name;
      logic [7:0] bits;
      int         nbits;
      int         stride;
      bit         pe;
      logic [4:0] d;
      logic       perr;
      logic       ferr;
      int         lat;
      int         bsy;
   } vec_t;
   vec_t vt[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input logic xv, input logic ev);
      @(negedge clk);
      x  = xv;
      en = ev;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      x = 1'b1;
      en = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic run_vec(input vec_t v);
      int vb, bb, es;
      do_reset();
      @(negedge clk);
      vb = v.pe ? vcnt_p : vcnt_n;
      bb = v.pe ? bcnt_p : bcnt_n;
      es = 0;
      for (int i = 0; i < v.nbits; i++) begin
         step(v.bits[i], 1'b1);
         if (i == 0) es = cyc + 1;
         for (int s = 1; s < v.stride; s++) step(~v.bits[i], 1'b0);
      end
      repeat (4) step(1'b1, 1'b1);
      @(negedge clk);
      chk({v.name, " valid count"}, v.pe ? vcnt_p - vb : vcnt_n - vb, 1);
      chk({v.name, " data"}, v.pe ? data_p : data_n, v.d);
      chk({v.name, " par_err"}, v.pe ? par_p : par_n, v.perr);
      chk({v.name, " frm_err"}, v.pe ? frm_p : frm_n, v.ferr);
      chk({v.name, " latency"}, (v.pe ? vcyc_p : vcyc_n) - es, v.lat);
      chk({v.name, " busy cycles"}, v.pe ? bcnt_p - bb : bcnt_n - bb, v.bsy);
   endtask

   initial begin
      int vb, bb;
      logic [13:0] b2b;
      // bits listed first-on-the-wire in bit 0
      vt[0] = '{"good",        8'b11101100, 8, 1, 1'b1, 5'b10110, 1'b0, 1'b0, 7, 7};
      vt[1] = '{"stop_err",    8'b01000010, 8, 1, 1'b1, 5'b00001, 1'b0, 1'b1, 7, 7};
      vt[2] = '{"par_err",     8'b10000010, 8, 1, 1'b1, 5'b00001, 1'b1, 1'b0, 7, 7};
      vt[3] = '{"stall",       8'b11101100, 8, 3, 1'b1, 5'b10110, 1'b0, 1'b0, 21, 21};
      vt[4] = '{"nopar_good",  8'b01101010, 7, 1, 1'b0, 5'b10101, 1'b0, 1'b0, 6, 6};
      vt[5] = '{"nopar_frm",   8'b00100110, 7, 1, 1'b0, 5'b10011, 1'b0, 1'b1, 6, 6};

      // reset with en and a start level present: reset must win
      @(negedge clk);
      reset = 1'b0;
      x = 1'b0;
      en = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst data", data_p, 5'd0);
      chk("rst valid", valid_p, 1'b0);
      chk("rst par_err", par_p, 1'b0);
      chk("rst frm_err", frm_p, 1'b0);
      chk("rst busy", {busy_p, busy_n}, 2'b00);
      x = 1'b1;
      reset = 1'b1;
      vb = vcnt_p;
      bb = bcnt_p;
      repeat (10) step(1'b1, 1'b1);
      @(negedge clk);
      chk("idle valid count", vcnt_p - vb, 0);
      chk("idle busy cycles", bcnt_p - bb, 0);
      chk("idle data", data_p, 5'd0);

      foreach (vt[i]) run_vec(vt[i]);

      // reset mid-frame after d2, then a fresh frame
      do_reset();
      vb = vcnt_p;
      step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      step(1'b1, 1'b0);
      chk("midrst busy before", busy_p, 1'b1);
      #2 reset = 1'b0;
      #1;
      chk("midrst busy async", busy_p, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      chk("midrst no valid", vcnt_p - vb, 0);
      for (int i = 0; i < 8; i++) step(i == 0 ? 1'b0 : 1'b1, 1'b1);
      repeat (3) step(1'b1, 1'b1);
      @(negedge clk);
      chk("midrst valid count", vcnt_p - vb, 1);
      chk("midrst data", data_p, 5'b11111);
      chk("midrst par_err", par_p, 1'b0);
      chk("midrst frm_err", frm_p, 1'b0);

      // back-to-back frames without parity
      do_reset();
      vb = vcnt_n;
      b2b = 14'b10000001101010;
      for (int i = 0; i < 14; i++) begin
         step(b2b[i], 1'b1);
         if (i == 7) begin
            chk("b2b first valid", valid_n, 1'b1);
            chk("b2b first data", data_n, 5'b10101);
            chk("b2b first par_err", par_n, 1'b0);
         end
         if (i > 7) chk("b2b gap valid", valid_n, 1'b0);
      end
      step(1'b1, 1'b1);
      chk("b2b second valid", valid_n, 1'b1);
      chk("b2b second data", data_n, 5'b00000);
      chk("b2b second par_err", par_n, 1'b0);
      step(1'b1, 1'b1);
      chk("b2b valid drops", valid_n, 1'b0);
      @(negedge clk);
      chk("b2b valid count", vcnt_n - vb, 2);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
